// File: rtl/ps2_pkg.sv
// ps2_pkg: receiver state encoding and odd-parity helper shared by the PS/2 receiver
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    function automatic logic odd_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
endpackage

// File: rtl/ps2_filter.sv
// ps2_filter: synchronise a PS/2 clock line, deglitch it and strobe on each filtered falling edge
module ps2_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_fall
);
    localparam int CW = $clog2(FILTER_LEN);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);
    logic [1:0] sync;
    logic filt;
    logic [CW-1:0] cnt;
    logic flip;
    // cnt tracks how long the synchronised line has disagreed with the filtered value
    assign flip = (sync[1] != filt) && (cnt == LAST);
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync   <= 2'b11;
            filt   <= 1'b1;
            cnt    <= '0;
            o_fall <= 1'b0;
        end else begin
            sync   <= {sync[0], i_line};
            cnt    <= (sync[1] == filt || flip) ? '0 : cnt + 1'b1;
            filt   <= flip ? sync[1] : filt;
            o_fall <= flip && !sync[1];
        end
    end
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host byte receiver with parity, frame and timeout checking
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 3,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ps2_clk,
    input  logic               i_ps2_data,
    output logic               o_valid,
    output logic [7:0]         o_byte,
    output logic [8*DEPTH-1:0] o_data,
    output logic               o_err_parity,
    output logic               o_err_frame,
    output logic               o_err_timeout,
    output logic               o_busy
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
    state_t state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic par, par_n;
    logic [TW-1:0] timer, timer_n;
    logic [1:0] dsync;
    logic fall, d;
    logic good, perr, ferr, tout;
    logic [8*DEPTH-1:0] data_n;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_line (i_ps2_clk),
        .o_fall (fall)
    );

    assign d      = dsync[1];
    assign o_busy = state != IDLE;

    generate
        if (DEPTH == 1) begin : g_one
            assign data_n = shift;
        end else begin : g_hist
            assign data_n = {o_data[8*DEPTH-9:0], shift};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dsync   <= 2'b11;
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par     <= 1'b0;
            timer   <= '0;
        end else begin
            dsync   <= {dsync[0], i_ps2_data};
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            par     <= par_n;
            timer   <= timer_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_n     = par;
        timer_n   = (state == IDLE || fall) ? '0 : timer + 1'b1;
        good      = 1'b0;
        perr      = 1'b0;
        ferr      = 1'b0;
        tout      = 1'b0;
        if (fall) begin
            case (state)
                IDLE: begin
                    state_n   = d ? IDLE : DATA;
                    bit_cnt_n = '0;
                end
                DATA: begin
                    shift_n   = {d, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    state_n   = (bit_cnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = d;
                    state_n = STOP;
                end
                default: begin
                    state_n = IDLE;
                    ferr    = !d;
                    perr    = d && !odd_ok(shift, par);
                    good    = d && odd_ok(shift, par);
                end
            endcase
        end else if (state != IDLE && timer == TMAX) begin
            tout    = 1'b1;
            state_n = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid       <= 1'b0;
            o_err_parity  <= 1'b0;
            o_err_frame   <= 1'b0;
            o_err_timeout <= 1'b0;
            o_byte        <= '0;
            o_data        <= '0;
        end else begin
            o_valid       <= good;
            o_err_parity  <= perr;
            o_err_frame   <= ferr;
            o_err_timeout <= tout;
            if (good) begin
                o_byte <= shift;
                o_data <= data_n;
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed frames against ps2_rx with strobe counters and hand-computed expectations
module tb_ps2_rx;
    localparam int TO = 200;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic o_valid, o_err_parity, o_err_frame, o_err_timeout, o_busy;
    logic [7:0] o_byte;
    logic [23:0] o_data;
    int n_tests = 0;
    int n_fail = 0;
    int n_valid = 0, n_perr = 0, n_ferr = 0, n_tout = 0, n_multi = 0;

    ps2_rx #(.DEPTH(3), .FILTER_LEN(4), .TIMEOUT_CYC(TO)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ps2_clk     (ps2_clk),
        .i_ps2_data    (ps2_data),
        .o_valid       (o_valid),
        .o_byte        (o_byte),
        .o_data        (o_data),
        .o_err_parity  (o_err_parity),
        .o_err_frame   (o_err_frame),
        .o_err_timeout (o_err_timeout),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            n_valid += int'(o_valid);
            n_perr  += int'(o_err_parity);
            n_ferr  += int'(o_err_frame);
            n_tout  += int'(o_err_timeout);
            if (int'(o_valid) + int'(o_err_parity) + int'(o_err_frame) + int'(o_err_timeout) > 1)
                n_multi++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_clk(10);
            if (glitch) begin
                ps2_clk = 1'b0;
                wait_clk(2);
                ps2_clk = 1'b1;
                wait_clk(8);
            end
            ps2_clk = 1'b0;
            wait_clk(20);
            ps2_clk = 1'b1;
            wait_clk(10);
        end
        ps2_data = 1'b1;
        wait_clk(20);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop, input bit glitch);
        send_bits({stop, (~^b) ^ bad_par, b, 1'b0}, 11, glitch);
    endtask

    initial begin
        wait_clk(3);
        @(negedge clk);
        rst = 1'b0;
        check("reset o_valid", 32'(o_valid), 0);
        check("reset o_byte", 32'(o_byte), 0);
        check("reset o_data", 32'(o_data), 0);
        check("reset o_busy", 32'(o_busy), 0);
        check("reset errs", {29'd0, o_err_parity, o_err_frame, o_err_timeout}, 0);

        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("three valid", 32'(n_valid), 3);
        check("byte 5A", 32'(o_byte), 32'h5A);
        check("data F01C5A", 32'(o_data), 32'hF01C5A);
        check("idle after frames", 32'(o_busy), 0);

        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        check("parity err", 32'(n_perr), 1);
        check("parity data held", 32'(o_data), 32'hF01C5A);
        check("parity no valid", 32'(n_valid), 3);

        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("frame err", 32'(n_ferr), 1);
        check("frame no parity err", 32'(n_perr), 1);
        check("frame no valid", 32'(n_valid), 3);
        check("frame byte held", 32'(o_byte), 32'h5A);

        send_frame(8'h29, 1'b0, 1'b1, 1'b1);
        check("glitch valid", 32'(n_valid), 4);
        check("glitch byte 29", 32'(o_byte), 32'h29);
        check("glitch data", 32'(o_data), 32'h1C5A29);

        send_bits({5'b11010, 6'b010110}, 6, 1'b0);
        check("busy mid frame", 32'(o_busy), 1);
        check("no timeout yet", 32'(n_tout), 0);
        wait_clk(TO + 50);
        check("timeout strobe", 32'(n_tout), 1);
        check("timeout busy low", 32'(o_busy), 0);
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        check("after timeout valid", 32'(n_valid), 5);
        check("after timeout data", 32'(o_data), 32'h5A2929);

        send_bits({6'b111111, 5'b10110}, 5, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst o_data", 32'(o_data), 0);
        check("mid rst o_byte", 32'(o_byte), 0);
        check("mid rst o_busy", 32'(o_busy), 0);
        check("mid rst strobes", {28'd0, o_valid, o_err_parity, o_err_frame, o_err_timeout}, 0);
        send_frame(8'h45, 1'b0, 1'b1, 1'b0);
        check("post rst valid", 32'(n_valid), 6);
        check("post rst byte 45", 32'(o_byte), 32'h45);
        check("post rst data", 32'(o_data), 32'h000045);
        check("no stray errs", 32'(n_perr + n_ferr + n_tout), 3);
        check("strobes exclusive", 32'(n_multi), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 3: number of received bytes held in o_data (DEPTH >= 1).
REQ-002 SHALL have parameter FILTER_LEN, default 4: consecutive equal synchronised samples needed to change the filtered PS/2 clock (FILTER_LEN >= 2).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 5000: i_clk cycles without a filtered falling edge before a partial frame is abandoned.
REQ-004 SHALL have port i_clk  input  1  system clock; every flop is clocked on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset; one clock, synchronous, active-high.
REQ-006 SHALL have port i_ps2_clk  input  1  asynchronous PS/2 clock line.
REQ-007 SHALL have port i_ps2_data  input  1  asynchronous PS/2 data line.
REQ-008 SHALL have port o_valid  output  1  one-cycle strobe: a good byte was received.
REQ-009 SHALL have port o_byte  output  8  last good byte; held until the next good byte.
REQ-010 SHALL have port o_data  output  8*DEPTH  history of good bytes, newest in bits [7:0].
REQ-011 SHALL have port o_err_parity  output  1  one-cycle strobe: parity error.
REQ-012 SHALL have port o_err_frame  output  1  one-cycle strobe: stop bit was 0.
REQ-013 SHALL have port o_err_timeout  output  1  one-cycle strobe: frame abandoned by timeout.
REQ-014 SHALL have port o_busy  output  1  high while state is not IDLE.

Function
REQ-015 SHALL pass both lines through a 2-flop synchroniser.
REQ-016 SHALL change the filtered clock only after FILTER_LEN consecutive equal synchronised clock samples; shorter pulses are ignored.
REQ-017 SHALL generate "fall" as a one-cycle pulse when the filtered clock goes 1->0, and sample the synchronised data only on fall.
REQ-018 SHALL use states IDLE, DATA, PARITY, STOP; IDLE->DATA on fall with data 0 (start bit), IDLE stays on fall with data 1.
REQ-019 SHALL shift 8 data bits LSB-first in DATA using a 3-bit counter, then go DATA->PARITY after bit 7, PARITY->STOP on the next fall, and STOP->IDLE on the next fall.
REQ-020 SHALL check odd parity: popcount of the 8 data bits plus the parity bit is odd.
REQ-021 SHALL, on fall in STOP with stop=1 and parity good, in the next cycle: pulse o_valid, load o_byte, and set o_data to {o_data[8*DEPTH-9:0], byte}, or just byte when DEPTH=1.
REQ-022 SHALL, on fall in STOP with stop=0, pulse o_err_frame only, with o_byte and o_data unchanged; frame error takes priority over parity error.
REQ-023 SHALL, on fall in STOP with stop=1 and parity bad, pulse o_err_parity only, with o_byte and o_data unchanged.
REQ-024 SHALL count i_clk cycles in non-IDLE states, clear the count on every fall, and at TIMEOUT_CYC pulse o_err_timeout, return to IDLE and discard the partial frame.
REQ-025 SHALL assert at most one of o_valid/o_err_* in any cycle; a strobe lasts exactly one cycle.

Reset
REQ-026 SHALL, with i_rst high, drive o_valid, o_err_*, o_busy, o_byte and o_data to 0, set state IDLE, clear the bit counter and timer, and set synchroniser/filter flops to 1 (idle bus).
REQ-027 SHALL discard any partial frame on reset mid-frame; the first fall after reset is treated as a possible start bit.

Structure
REQ-028 SHALL put the state enum and the odd-parity function in shared package ps2_pkg.
REQ-029 SHALL implement the synchroniser, filter and fall detect as sub-module ps2_filter (parameter FILTER_LEN), instantiated once for the clock line.

Verification
REQ-030 SHALL cover: frames 0xF0, 0x1C, 0x5A with correct parity -> three o_valid pulses, o_byte=0x5A, o_data=24'hF01C5A.
REQ-031 SHALL cover: 0x1C with parity bit 1 -> o_err_parity pulse, o_data unchanged.
REQ-032 SHALL cover: 0x1C with good parity and stop=0 -> o_err_frame only.
REQ-033 SHALL cover: with FILTER_LEN=4, 2-cycle low glitches on i_ps2_clk during a 0x29 frame -> no extra bits, o_byte=0x29.
REQ-034 SHALL cover: frame stopped after 5 bits, idle for TIMEOUT_CYC -> o_err_timeout pulse, o_busy low; a following 0x29 frame is accepted.
REQ-035 SHALL cover: i_rst for 1 cycle after 4 data bits, then a full 0x45 frame -> all outputs 0 after reset, then o_valid with o_byte=0x45.
